// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Opcode map, FSM state encoding and requester-id type.
// Pure declarations; no logic, so no latency or backpressure of its own.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_SHR = 4'd2;
    localparam logic [OP_W-1:0] OP_SHL = 4'd3;
    localparam logic [OP_W-1:0] OP_ROR = 4'd4;
    localparam logic [OP_W-1:0] OP_ROL = 4'd5;
    localparam logic [OP_W-1:0] OP_AND = 4'd6;
    localparam logic [OP_W-1:0] OP_OR  = 4'd7;
    localparam logic [OP_W-1:0] OP_NOT = 4'd8;
    localparam logic [OP_W-1:0] OP_XOR = 4'd9;
    localparam logic [OP_W-1:0] OP_MAX = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef logic req_id_t;

    // Opcodes above OP_MAX are reserved and reported as errors.
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// 8-bit combinational ALU shared by the arbiter's requesters.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows inputs every cycle.
module ALU
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y
);

    logic [2*DATA_W-1:0] ror_tmp;
    logic [2*DATA_W-1:0] rol_tmp;

    // Operation decode; rotates use only the low three bits of b, reserved opcodes yield zero
    always_comb begin
        ror_tmp = {a, a} >> b[2:0];
        rol_tmp = {a, a} << b[2:0];
        y       = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SHR:  y = a >> b;
            OP_SHL:  y = a << b;
            OP_ROR:  y = ror_tmp[DATA_W-1:0];
            OP_ROL:  y = rol_tmp[2*DATA_W-1:DATA_W];
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Latency: request accepted in cycle T gives response valid at T+2.
// Backpressure: response holds until consumed; no new request accepted meanwhile.
// Optional grant locking is compiled in with ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic              req0_lock,
    input  logic              req1_lock,
`endif
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp0_err,
    output logic              rsp1_err,
    output logic              busy
);

    state_t            state;
    req_id_t           owner;
    req_id_t           prio;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [OP_W-1:0]   cap_op;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp0_q;
    logic              rsp1_q;
    logic [DATA_W-1:0] alu_y;

    logic              gnt_vld;
    req_id_t           gnt_id;
    logic              rsp_hs;

`ifdef ALU_ARB_LOCK_EN
    logic              lock_held;
    req_id_t           lock_owner;
    logic              cap_lock;
`endif

    // Grant selection, only evaluated in IDLE and suppressed while reset is asserted
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE && !rst) begin
`ifdef ALU_ARB_LOCK_EN
            if (lock_held) begin
                gnt_id  = lock_owner;
                gnt_vld = lock_owner ? req1_valid : req0_valid;
            end else
`endif
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = prio;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld && (gnt_id == 1'b0);
    assign req1_ready = gnt_vld && (gnt_id == 1'b1);

    assign rsp_hs     = (rsp0_q && rsp0_ready) || (rsp1_q && rsp1_ready);

    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp0_data  = rsp_data;
    assign rsp1_data  = rsp_data;
    assign rsp0_err   = rsp_err;
    assign rsp1_err   = rsp_err;
    assign busy       = (state != IDLE);

    ALU u_alu (
        .a  (cap_a),
        .b  (cap_b),
        .op (cap_op),
        .y  (alu_y)
    );

    // Arbiter FSM: capture on grant, register ALU result, hold response until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            prio     <= 1'b0;
            cap_a    <= '0;
            cap_b    <= '0;
            cap_op   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_held  <= 1'b0;
            lock_owner <= 1'b0;
            cap_lock   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        owner  <= gnt_id;
                        cap_a  <= gnt_id ? req1_a  : req0_a;
                        cap_b  <= gnt_id ? req1_b  : req0_b;
                        cap_op <= gnt_id ? req1_op : req0_op;
`ifdef ALU_ARB_LOCK_EN
                        cap_lock <= gnt_id ? req1_lock : req0_lock;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_y;
                    rsp_err  <= op_illegal(cap_op);
                    rsp0_q   <= (owner == 1'b0);
                    rsp1_q   <= (owner == 1'b1);
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_q <= 1'b0;
                        rsp1_q <= 1'b0;
                        state  <= IDLE;
`ifdef ALU_ARB_LOCK_EN
                        // A locked op keeps the grant with its owner; an unlocked one releases it
                        lock_held  <= cap_lock;
                        lock_owner <= owner;
                        prio       <= cap_lock ? prio : ~owner;
`else
                        prio   <= ~owner;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with hand-computed expected values.
// Inputs driven on the falling edge, outputs sampled away from the rising edge.
// Lock scenario runs only when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req1_a, req0_b, req1_b;
    logic [3:0] req0_op, req1_op;
    logic       req0_lock, req1_lock;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic       rsp0_err, rsp1_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req1_a     (req1_a),
        .req0_b     (req0_b),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock  (req0_lock),
        .req1_lock  (req1_lock),
`endif
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_ready (rsp1_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_data  (rsp1_data),
        .rsp0_err   (rsp0_err),
        .rsp1_err   (rsp1_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int who, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op);
        if (who == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        req0_lock = 1'b0; req1_lock = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_r0rdy"}, 32'(req0_ready), 0);
        chk({tag, "_r1rdy"}, 32'(req1_ready), 0);
        chk({tag, "_v0"},    32'(rsp0_valid), 0);
        chk({tag, "_v1"},    32'(rsp1_valid), 0);
        chk({tag, "_data"},  32'(rsp0_data),  0);
        chk({tag, "_err"},   32'(rsp0_err),   0);
        chk({tag, "_busy"},  32'(busy),       0);
    endtask

    // One isolated request with response ready held high; checks T, T+1 and T+2.
    task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input int exp_d, input int exp_e);
        @(negedge clk);
        drive(who, 1'b1, a, b, op);
        #1;
        chk("grant_rdy", 32'(who ? req1_ready : req0_ready), 1);
        chk("other_rdy", 32'(who ? req0_ready : req1_ready), 0);
        @(posedge clk);
        #1 drive(who, 1'b0, a, b, op);
        @(negedge clk);
        chk("rsp_early", 32'(rsp0_valid | rsp1_valid), 0);
        chk("busy_exec", 32'(busy), 1);
        @(negedge clk);
        chk("rsp_valid", 32'(who ? rsp1_valid : rsp0_valid), 1);
        chk("rsp_other", 32'(who ? rsp0_valid : rsp1_valid), 0);
        chk("rsp_data",  32'(who ? rsp1_data : rsp0_data), 32'(exp_d));
        chk("rsp_err",   32'(who ? rsp1_err : rsp0_err), 32'(exp_e));
    endtask

    typedef struct {
        int         who;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        int         d;
        int         e;
    } vec_t;

    vec_t vecs[8];
    int   seq[4];
    int   n;

    initial begin
        vecs[0] = '{0, 8'h00, 8'h01, OP_SUB, 32'hFF, 0};
        vecs[1] = '{1, 8'h80, 8'h03, OP_SHR, 32'h10, 0};
        vecs[2] = '{0, 8'h81, 8'h01, OP_SHL, 32'h02, 0};
        vecs[3] = '{1, 8'h81, 8'h01, OP_ROL, 32'h03, 0};
        vecs[4] = '{0, 8'hF0, 8'h3C, OP_AND, 32'h30, 0};
        vecs[5] = '{1, 8'h5A, 8'h00, OP_NOT, 32'hA5, 0};
        vecs[6] = '{0, 8'hAA, 8'hFF, OP_XOR, 32'h55, 0};
        vecs[7] = '{1, 8'h12, 8'h34, 4'hF,   32'h00, 1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk_reset_vals("reset");

        // Wrapping add from requester 0
        run_op(0, 8'hFF, 8'h02, OP_ADD, 32'h01, 0);

        // Ties alternate starting with requester 0 after reset
        do_reset();
        @(negedge clk);
        drive(0, 1'b1, 8'h01, 8'h02, OP_ADD);
        drive(1, 1'b1, 8'h05, 8'h03, OP_SUB);
        n = 0;
        for (int i = 0; i < 4; i++) seq[i] = 9;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            chk("both_rdy", 32'(req0_ready & req1_ready), 0);
            if (req0_ready) begin seq[n] = 0; n++; end
            else if (req1_ready) begin seq[n] = 1; n++; end
            if (rsp0_valid) chk("tie_d0", 32'(rsp0_data), 32'h03);
            if (rsp1_valid) chk("tie_d1", 32'(rsp1_data), 32'h02);
            chk("tie_v_excl", 32'(rsp0_valid & rsp1_valid), 0);
            @(negedge clk);
        end
        chk("tie_count", 32'(n), 4);
        chk("tie_g0", 32'(seq[0]), 0);
        chk("tie_g1", 32'(seq[1]), 1);
        chk("tie_g2", 32'(seq[2]), 0);
        chk("tie_g3", 32'(seq[3]), 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("tie_idle", 32'(busy), 0);

        // Response backpressure on requester 1 blocks requester 0
        rsp1_ready = 1'b0;
        drive(1, 1'b1, 8'h81, 8'h01, OP_ROR);
        #1 chk("bp_r1rdy", 32'(req1_ready), 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        drive(0, 1'b1, 8'h10, 8'h20, OP_ADD);
        @(negedge clk);
        chk("bp_exec_r0rdy", 32'(req0_ready), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_v1",    32'(rsp1_valid), 1);
            chk("bp_data",  32'(rsp1_data),  32'hC0);
            chk("bp_busy",  32'(busy),       1);
            chk("bp_r0rdy", 32'(req0_ready), 0);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", 32'(rsp1_valid), 0);
        chk("bp_r0_grant", 32'(req0_ready), 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_r0_v",    32'(rsp0_valid), 1);
        chk("bp_r0_data", 32'(rsp0_data),  32'h30);

        // Illegal opcode then a legal one
        run_op(0, 8'h12, 8'h34, 4'hC, 32'h00, 1);
        run_op(0, 8'h0F, 8'hF0, OP_OR, 32'hFF, 0);

        // Remaining opcodes and boundary values
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d, vecs[i].e);

        // Reset while in EXEC discards the operation
        @(negedge clk);
        drive(0, 1'b1, 8'h01, 8'h01, OP_ADD);
        #1 chk("rst_exec_rdy", 32'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals("rst_exec");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
        end
        run_op(1, 8'h40, 8'h02, OP_ADD, 32'h42, 0);

`ifdef ALU_ARB_LOCK_EN
        // Locked requester keeps the grant until it issues unlocked
        do_reset();
        @(negedge clk);
        drive(0, 1'b1, 8'h01, 8'h01, OP_ADD);
        drive(1, 1'b1, 8'h02, 8'h02, OP_ADD);
        n = 0;
        for (int i = 0; i < 4; i++) seq[i] = 9;
        for (int c = 0; c < 40 && n < 4; c++) begin
            req0_lock = (n < 2);
            #1;
            if (req0_ready) begin seq[n] = 0; n++; end
            else if (req1_ready) begin seq[n] = 1; n++; end
            @(negedge clk);
        end
        chk("lock_count", 32'(n), 4);
        chk("lock_g0", 32'(seq[0]), 0);
        chk("lock_g1", 32'(seq[1]), 0);
        chk("lock_g2", 32'(seq[2]), 0);
        chk("lock_g3", 32'(seq[3]), 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one 8-bit ALU between two independent requesters.
- Each requester submits an (A, B, opcode) operation over a valid/ready handshake. The arbiter grants the ALU round-robin, captures the operands and registers the ALU result. It returns the result to the granted requester over a valid/ready response channel.
- Sits between the two datapath clients and the ALU. It is the only block that drives the ALU inputs.

## Interface
Parameters:
- None. Widths are fixed: data 8, opcode 4.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  — request valid.
- `req0_ready`, `req1_ready`  out  1  — request accepted this cycle.
- `req0_a`, `req1_a`  in  8  — operand A.
- `req0_b`, `req1_b`  in  8  — operand B.
- `req0_op`, `req1_op`  in  4  — ALU opcode.
- `req0_lock`, `req1_lock`  in  1  — hold grant; present only with `ALU_ARB_LOCK_EN`.
- `rsp0_valid`, `rsp1_valid`  out  1  — result valid.
- `rsp0_ready`, `rsp1_ready`  in  1  — result consumed.
- `rsp0_data`, `rsp1_data`  out  8  — result, shared register value.
- `rsp0_err`, `rsp1_err`  out  1  — opcode was 10–15.
- `busy`  out  1  — state ≠ IDLE.

## Operation
State machine with three states:
- **IDLE**
  - If any `reqN_valid` is high, select a requester as the grant:
    - both valid → the requester named by `prio`;
    - one valid → that requester.
  - Assert `reqN_ready` combinationally for the granted requester only. The handshake completes this cycle.
  - Capture A, B, op and owner into registers. Go to EXEC.
- **EXEC**
  - ALU inputs come from the captured registers.
  - Register the ALU output into `rsp_data`.
  - `rsp_err` = (op > 9).
  - Assert the owner's `rspN_valid`. Go to RESP.
- **RESP**
  - Hold `rspN_valid`, data and err stable until `rspN_ready` is high.
  - On the handshake: drop valid, update `prio` to the non-owner, go to IDLE.

Arithmetic and operand rules:
- ALU arithmetic wraps modulo 256.
- B is passed unmodified. Shift and rotate results for B ≥ 8 are whatever the ALU produces.
- Illegal opcode: data = 0x00, err = 1.

Rules on the outputs:
- `rsp_data` and `rsp_err` are a single register pair. Only the owner's `rspN_valid` is ever high.
- `reqN_ready` is never high outside IDLE.
- `reqN_ready` is never high for both requesters in the same cycle.

Reset:
- Reset values: all `ready` 0, `rsp0_valid` and `rsp1_valid` 0, `rsp_data` 0x00, `rsp_err` 0, `busy` 0, `prio` 0, state IDLE.
- Reset mid-operation discards the in-flight op with no response.

## Timing
- Request accepted in cycle T → `rspN_valid` high at T+2.
- Minimum issue interval: 3 cycles with `rsp_ready` held high.
- Response backpressure extends RESP indefinitely. No new request is accepted meanwhile.
- A requester's valid deasserting or changing before its `ready` is legal. The arbiter re-evaluates every IDLE cycle.
- Grant decisions are made only in IDLE. A valid arriving during EXEC/RESP waits.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - `reqN_lock` ports exist.
  - A request accepted with lock=1 sets `lock_held`, owned by that requester.
  - While `lock_held` is set, IDLE grants only the lock owner, and `prio` is not toggled.
  - An accepted request from the lock owner with lock=0 clears `lock_held` after its response.
  - Reset clears `lock_held`.
- `ALU_ARB_LOCK_EN` undefined:
  - No lock ports.
  - Pure round-robin.

## Structure
- Package `alu_arb_pkg` holds:
  - opcode constants: `OP_ADD`=0, `OP_SUB`, `OP_SHR`, `OP_SHL`, `OP_ROR`, `OP_ROL`, `OP_AND`, `OP_OR`, `OP_NOT`, `OP_XOR`=9, and `OP_MAX`=9;
  - the state enum `{IDLE, EXEC, RESP}`;
  - the requester-id type (1 bit).
- Exactly one sub-module: the team's 8-bit ALU (`ALU`), instantiated once and fed from the captured operand registers.

## Test plan
- Reset, then req0 ADD A=0xFF B=0x02 → `req0_ready` in cycle T; `rsp0_valid` at T+2 with data 0x01, err 0; `rsp1_valid` stays 0.
- req0 and req1 valid together after reset, `rsp_ready` held high → req0 served first, then req1. Repeated ties alternate 0,1,0,1.
- req1 ROR A=0x81 B=1 with `rsp1_ready` low for 5 cycles → data 0xC0 held stable, `busy` 1, `req0_ready` stays 0 despite `req0_valid`.
- req0 op=4'hC → data 0x00, err 1. The next legal op returns err 0.
- Assert `rst` during EXEC → next cycle all outputs at reset values, no response is delivered, and a new request is accepted normally.
- With `ALU_ARB_LOCK_EN`:
  - req0 issues with lock=1, then both requesters stay valid → req0 granted consecutively;
  - req0 then issues with lock=0 → req1 is granted next.
